// File: rtl/rnn_step_sched.sv
// rnn_step_sched: sequences the shared FP datapath through one RNN step per
// row and timestep, with a one-command-outstanding handshake and a WAIT timeout.
`default_nettype none

module rnn_step_sched #(
  parameter int T_STEPS = 3,
  parameter int ROWS    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd_op,
  output logic [1:0] cmd_row,
  output logic [1:0] cmd_t,
  input  logic       rsp_valid,
  output logic       y_valid,
  output logic [3:0] y_index,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_DOT_UX   = 3'd0;
  localparam logic [2:0] OP_EXP_NEG  = 3'd3;
  localparam logic [2:0] OP_RELU_OUT = 3'd7;
  localparam logic [1:0] LAST_ROW    = 2'(ROWS - 1);
  localparam logic [1:0] LAST_T      = 2'(T_STEPS - 1);
  localparam logic [7:0] TMO_MAX     = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [1:0] row_q, row_d;
  logic [1:0] t_q, t_d;
  logic [7:0] tmo_q, tmo_d;
  logic       y_valid_q, y_valid_d;
  logic [3:0] y_index_q, y_index_d;
  logic       err_q, err_d;
  logic [7:0] tmo_inc;

  assign tmo_inc = tmo_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    row_d     = row_q;
    t_d       = t_q;
    tmo_d     = tmo_q;
    y_valid_d = 1'b0;
    y_index_d = y_index_q;
    err_d     = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      op_d    = '0;
      row_d   = '0;
      t_d     = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_ISSUE;
            op_d    = OP_DOT_UX;
            row_d   = '0;
            t_d     = '0;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            state_d = S_WAIT;
            tmo_d   = '0;
          end
        end
        S_WAIT: begin
          // A response arriving on the final allowed cycle beats the timeout.
          if (rsp_valid) begin
            state_d = S_ISSUE;
            if (op_q == OP_RELU_OUT) begin
              y_valid_d = 1'b1;
              y_index_d = 4'(int'(t_q) * ROWS + int'(row_q));
            end
            if (row_q != LAST_ROW) begin
              row_d = row_q + 2'd1;
            end else begin
              row_d = '0;
              if (op_q == OP_RELU_OUT) begin
                op_d = OP_DOT_UX;
                if (t_q == LAST_T) begin
                  state_d = S_DONE;
                  t_d     = '0;
                end else begin
                  t_d = t_q + 2'd1;
                end
              end else if (t_q == 2'd0 && op_q == OP_DOT_UX) begin
                // No recurrent terms at t=0: the hidden state is zero.
                op_d = OP_EXP_NEG;
              end else begin
                op_d = op_q + 3'd1;
              end
            end
          end else if (tmo_inc == TMO_MAX) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            op_d    = '0;
            row_d   = '0;
            t_d     = '0;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_inc;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      row_q     <= '0;
      t_q       <= '0;
      tmo_q     <= '0;
      y_valid_q <= 1'b0;
      y_index_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      row_q     <= row_d;
      t_q       <= t_d;
      tmo_q     <= tmo_d;
      y_valid_q <= y_valid_d;
      y_index_q <= y_index_d;
      err_q     <= err_d;
    end
  end

  assign cmd_valid = (state_q == S_ISSUE);
  assign cmd_op    = op_q;
  assign cmd_row   = row_q;
  assign cmd_t     = t_q;
  assign y_valid   = y_valid_q;
  assign y_index   = y_index_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule

`default_nettype wire

// File: doc/rnn_step_sched.md
RNN_STEP_SCHED -- requirements
Module: rnn_step_sched

Interface
REQ-001 The block SHALL have parameter T_STEPS, default 3, meaning the number of timesteps per sequence (1..3).
REQ-002 The block SHALL have parameter ROWS, default 3, meaning the hidden/output vector length (1..3).
REQ-003 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of WAIT cycles per command (1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit: a one-cycle sequence request.
REQ-007 The block SHALL have port abort, input, 1 bit: a synchronous abort.
REQ-008 The block SHALL have port cmd_valid, output, 1 bit: a command is presented to the shared FP datapath.
REQ-009 The block SHALL have port cmd_ready, input, 1 bit: the datapath accepts the command.
REQ-010 The block SHALL have port cmd_op, output, 3 bits, with encoding 0 DOT_UX, 1 DOT_WH, 2 ADD, 3 EXP_NEG, 4 ADD_ONE, 5 RECIP, 6 DOT_VH, 7 RELU_OUT.
REQ-011 The block SHALL have port cmd_row, output, 2 bits: the row index.
REQ-012 The block SHALL have port cmd_t, output, 2 bits: the timestep index.
REQ-013 The block SHALL have port rsp_valid, input, 1 bit: the datapath result for the outstanding command.
REQ-014 The block SHALL have port y_valid, output, 1 bit: a one-cycle pulse per completed RELU_OUT.
REQ-015 The block SHALL have port y_index, output, 4 bits, equal to t*ROWS+row of the completed output.
REQ-016 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-017 The block SHALL have port done, output, 1 bit: a one-cycle pulse at sequence end.
REQ-018 The block SHALL have port err, output, 1 bit: a one-cycle pulse on timeout.

Function
REQ-019 The block SHALL implement the states IDLE, ISSUE, WAIT and DONE.
REQ-020 In IDLE, start=1 SHALL load t=0, op=DOT_UX, row=0 and move to ISSUE; start in any other state SHALL be ignored.
REQ-021 In ISSUE, cmd_valid SHALL be 1 and cmd_op/cmd_row/cmd_t SHALL be held stable until cmd_ready=1, then the block SHALL go to WAIT and clear the timeout counter.
REQ-022 In WAIT, cmd_valid SHALL be 0; rsp_valid=1 SHALL advance to the next command (ISSUE) or, after the last command, to DONE.
REQ-023 rsp_valid outside WAIT SHALL be ignored.
REQ-024 Command order SHALL be: the op loop outer (ascending encoding), the row loop inner (0..ROWS-1), and the timestep loop outermost.
REQ-025 For t=0, DOT_WH and ADD SHALL be skipped (h0=0), giving 6*ROWS commands; each t>0 SHALL issue 8*ROWS commands.
REQ-026 y_valid SHALL pulse in the cycle after the RELU_OUT rsp_valid, with y_index valid in that same cycle.
REQ-027 DONE SHALL last one cycle with done=1 and then return to IDLE; busy SHALL be 0 in IDLE only.
REQ-028 The timeout counter SHALL increment every WAIT cycle without rsp_valid; on reaching TIMEOUT, err SHALL pulse one cycle and the state SHALL go to IDLE without asserting done.
REQ-029 If rsp_valid is 1 in the same cycle the counter reaches TIMEOUT, the response SHALL win and no err SHALL be raised.
REQ-030 abort=1 in any state SHALL force IDLE on the next edge, deassert cmd_valid, and suppress done, y_valid and err; abort SHALL have priority over all other events.
REQ-031 Simultaneous start and abort in IDLE SHALL leave the block in IDLE.
REQ-032 With cmd_ready=1 and rsp_valid in the first WAIT cycle, each command SHALL take exactly 2 cycles.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE and clear all counters; cmd_valid, cmd_op, cmd_row, cmd_t, y_valid, y_index, busy, done and err SHALL all be 0.
REQ-034 Reset asserted mid-sequence SHALL discard all progress; the next start SHALL begin at t=0 with DOT_UX and row 0.

Verification
REQ-035 Default params, cmd_ready=1, 0-latency responder, start at cycle 0 -> 66 commands, first command (DOT_UX,0,0) in cycle 1, done in cycle 133, 9 y_valid pulses with y_index 0..8 in order.
REQ-036 Hold cmd_ready=0 for 5 cycles on the 3rd command -> cmd_op/cmd_row stay stable for all 5 cycles, and done is delayed by exactly 5 cycles.
REQ-037 Withhold rsp_valid on command 10 -> err pulses after 15 WAIT cycles, followed by IDLE with busy=0 and no done; rsp_valid on cycle 15 instead -> no err.
REQ-038 abort during WAIT of t=1 -> IDLE next cycle with no done; a fresh start then issues (DOT_UX,row0,t0).
REQ-039 T_STEPS=1, ROWS=2 -> 12 commands with no DOT_WH/ADD, y_index 0 and 1, and done in cycle 25.
REQ-040 rst_n pulsed low mid-sequence plus start during busy -> all outputs are 0 immediately, and a start while busy causes no restart.
